// File: rtl/freq_meter.sv
// freq_meter: counts sync'd rising edges of sig_in over a gate window.
// Optional period measurement enabled by FREQ_METER_PERIOD_EN.
module freq_meter #(
  parameter int GATE_CYCLES = 50000000,
  parameter int CNT_W       = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq,
  output logic             valid,
  output logic             overflow,
  output logic             busy
`ifdef FREQ_METER_PERIOD_EN
  ,
  output logic [CNT_W-1:0] period,
  output logic             period_valid
`endif
);

  localparam int GW =
    (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0] LAST = GW'(GATE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GATE,
    S_LATCH
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_busy;
  logic             r_s1;
  logic             r_s2;
  logic             r_s3;
  logic             w_edge;
  logic             w_full;
  logic [GW-1:0]    r_gate_cnt;
  logic [CNT_W-1:0] r_edge_cnt;
  logic             r_sat;
  logic [CNT_W-1:0] r_freq;
  logic             r_valid;
  logic             r_ovf;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= sig_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_edge = r_s2 & ~r_s3;
  assign w_full = &r_edge_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (enable) w_next = S_GATE;
      S_GATE: begin
        if (!enable)                 w_next = S_IDLE;
        else if (r_gate_cnt == LAST) w_next = S_LATCH;
      end
      S_LATCH: w_next = enable ? S_GATE : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    unique case (r_state)
      S_GATE, S_LATCH: w_busy = 1'b1;
      default:         w_busy = 1'b0;
    endcase
  end

  // An edge seen while latching opens the next window's count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_gate_cnt <= '0;
      r_edge_cnt <= '0;
      r_sat      <= 1'b0;
    end else begin
      unique case (r_state)
        S_GATE: begin
          r_gate_cnt <= r_gate_cnt + 1'b1;
          if (w_edge) begin
            if (w_full) r_sat      <= 1'b1;
            else        r_edge_cnt <= r_edge_cnt + 1'b1;
          end
        end
        S_LATCH: begin
          r_gate_cnt <= '0;
          r_edge_cnt <= CNT_W'(w_edge);
          r_sat      <= 1'b0;
        end
        default: begin
          r_gate_cnt <= '0;
          r_edge_cnt <= '0;
          r_sat      <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_freq  <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_valid <= (r_state == S_LATCH);
      if (r_state == S_LATCH) begin
        r_freq <= r_edge_cnt;
        r_ovf  <= r_sat;
      end
    end
  end

  assign freq     = r_freq;
  assign valid    = r_valid;
  assign overflow = r_ovf;
  assign busy     = w_busy;

`ifdef FREQ_METER_PERIOD_EN
  logic             r_armed;
  logic [CNT_W-1:0] r_per_cnt;
  logic [CNT_W-1:0] r_period;
  logic             r_pvalid;

  // First edge after enable only arms; later edges report the gap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_armed   <= 1'b0;
      r_per_cnt <= '0;
      r_period  <= '0;
      r_pvalid  <= 1'b0;
    end else if (!enable) begin
      r_armed   <= 1'b0;
      r_per_cnt <= '0;
      r_pvalid  <= 1'b0;
    end else if (w_edge) begin
      r_armed   <= 1'b1;
      r_per_cnt <= CNT_W'(1);
      r_pvalid  <= r_armed;
      if (r_armed) r_period <= r_per_cnt;
    end else begin
      r_pvalid <= 1'b0;
      if (!(&r_per_cnt)) r_per_cnt <= r_per_cnt + 1'b1;
    end
  end

  assign period       = r_period;
  assign period_valid = r_pvalid;
`endif

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: table-driven windows plus abort/reset/period sequences.
// Two DUTs (CNT_W=8 and CNT_W=3) share stimulus; GATE_CYCLES=100.
`timescale 1ns/1ps
module tb_freq_meter;

  localparam int G = 100;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       sig_in = 1'b0;
  logic [7:0] freq8;
  logic       valid8;
  logic       ovf8;
  logic       busy8;
  logic [2:0] freq3;
  logic       valid3;
  logic       ovf3;
  logic       busy3;
`ifdef FREQ_METER_PERIOD_EN
  logic [7:0] per8;
  logic       pv8;
  logic [2:0] per3;
  logic       pv3;
`endif

  always #5 clk = ~clk;

  freq_meter #(.GATE_CYCLES(G), .CNT_W(8)) u_dut8 (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .sig_in   (sig_in),
    .freq     (freq8),
    .valid    (valid8),
    .overflow (ovf8),
    .busy     (busy8)
`ifdef FREQ_METER_PERIOD_EN
    ,
    .period       (per8),
    .period_valid (pv8)
`endif
  );

  freq_meter #(.GATE_CYCLES(G), .CNT_W(3)) u_dut3 (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .sig_in   (sig_in),
    .freq     (freq3),
    .valid    (valid3),
    .overflow (ovf3),
    .busy     (busy3)
`ifdef FREQ_METER_PERIOD_EN
    ,
    .period       (per3),
    .period_valid (pv3)
`endif
  );

  typedef struct {
    int per;
    int wins;
    int e8;
    int e3;
    int o3;
  } vec_t;

  typedef struct packed {
    logic [7:0] f;
    logic       o;
  } exp_t;

  exp_t q8[$];
  exp_t q3[$];
  exp_t m8;
  exp_t m3;
  int   n_tests = 0;
  int   n_fail = 0;
  int   gen_per = 0;
  int   gen_cnt = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Square wave: high for the first half of each gen_per negedges.
  task automatic tick();
    @(negedge clk);
    if (gen_per == 0) begin
      sig_in = 1'b0;
    end else begin
      sig_in  = (gen_cnt < gen_per / 2);
      gen_cnt = (gen_cnt + 1) % gen_per;
    end
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!valid8 && n < max);
  endtask

  task automatic run_windows(input vec_t v);
    int n;
    gen_per = 0;
    enable  = 1'b0;
    repeat (5) tick();
    for (int w = 0; w < v.wins; w++) begin
      q8.push_back('{f: 8'(v.e8), o: 1'b0});
      q3.push_back('{f: 8'(v.e3), o: v.o3[0]});
    end
    gen_per = v.per;
    gen_cnt = 0;
    tick();
    enable = 1'b1;
    wait_valid(300, n);
    chk($sformatf("lat_first_p%0d", v.per), n - 1, G + 1);
    for (int w = 1; w < v.wins; w++) begin
      wait_valid(300, n);
      chk($sformatf("lat_next_p%0d", v.per), n, G + 1);
    end
    enable = 1'b0;
    tick();
    chk("q8_drain", q8.size(), 0);
    chk("q3_drain", q3.size(), 0);
  endtask

  always @(negedge clk) begin
    if (valid8) begin
      if (q8.size() == 0) begin
        chk("valid8_unexpected", 1, 0);
      end else begin
        m8 = q8.pop_front();
        chk("freq8", freq8, m8.f);
        chk("ovf8", ovf8, m8.o);
      end
    end
    if (valid3) begin
      if (q3.size() == 0) begin
        chk("valid3_unexpected", 1, 0);
      end else begin
        m3 = q3.pop_front();
        chk("freq3", freq3, m3.f);
        chk("ovf3", ovf3, m3.o);
      end
    end
  end

  vec_t tbl[8];

  initial begin
    int n;
    int np;
    tbl = '{
      '{per: 10,  wins: 2, e8: 10, e3: 7, o3: 1},
      '{per: 0,   wins: 3, e8: 0,  e3: 0, o3: 0},
      '{per: 4,   wins: 1, e8: 25, e3: 7, o3: 1},
      '{per: 20,  wins: 2, e8: 5,  e3: 5, o3: 0},
      '{per: 8,   wins: 1, e8: 13, e3: 7, o3: 1},
      '{per: 6,   wins: 1, e8: 17, e3: 7, o3: 1},
      '{per: 50,  wins: 1, e8: 2,  e3: 2, o3: 0},
      '{per: 100, wins: 1, e8: 1,  e3: 1, o3: 0}
    };

    repeat (3) tick();
    chk("rst_freq8", freq8, 0);
    chk("rst_valid8", valid8, 0);
    chk("rst_ovf8", ovf8, 0);
    chk("rst_busy8", busy8, 0);
    reset = 1'b1;
    repeat (3) tick();

    foreach (tbl[i]) run_windows(tbl[i]);

    // Abort at gate_cnt=50: no valid, results hold.
    gen_per = 0;
    repeat (5) tick();
    gen_per = 10;
    gen_cnt = 0;
    tick();
    enable = 1'b1;
    repeat (51) tick();
    chk("abort_busy_before", busy8, 1);
    enable = 1'b0;
    tick();
    chk("abort_busy_after", busy8, 0);
    repeat (150) tick();
    chk("abort_hold_freq8", freq8, 1);
    chk("abort_hold_ovf8", ovf8, 0);
    chk("abort_hold_freq3", freq3, 1);
    run_windows('{per: 10, wins: 1, e8: 10, e3: 7, o3: 1});

    // Reset in mid-window with sig_in toggling.
    gen_per = 10;
    gen_cnt = 0;
    tick();
    enable = 1'b1;
    repeat (40) tick();
    reset = 1'b0;
    #1;
    chk("mid_rst_freq8", freq8, 0);
    chk("mid_rst_ovf8", ovf8, 0);
    chk("mid_rst_valid8", valid8, 0);
    chk("mid_rst_busy8", busy8, 0);
    chk("mid_rst_freq3", freq3, 0);
    chk("mid_rst_ovf3", ovf3, 0);
    q8.delete();
    q3.delete();
    repeat (7) tick();
    q8.push_back('{f: 8'd10, o: 1'b0});
    q3.push_back('{f: 8'd7, o: 1'b1});
    gen_cnt = 0;
    tick();
    reset = 1'b1;
    wait_valid(300, n);
    chk("rst_release_lat", n - 1, G + 1);
    enable = 1'b0;
    tick();
    chk("rst_q8_drain", q8.size(), 0);

`ifdef FREQ_METER_PERIOD_EN
    gen_per = 0;
    repeat (5) tick();
    gen_per = 13;
    gen_cnt = 0;
    tick();
    enable = 1'b1;
    np = 0;
    for (int t = 0; t < 80; t++) begin
      tick();
      if (pv8) begin
        chk("period8", per8, 13);
        chk("period3_sat", per3, 7);
        np++;
      end
    end
    chk("period_pulses", np, 5);
    enable = 1'b0;
    repeat (5) tick();
`endif

    tick();
    chk("final_q8", q8.size(), 0);
    chk("final_q3", q3.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
